// File: rtl/accel_seq.sv
// accel_seq: command-driven memory read sequencer. It fetches a 4-word
// parameter block, then streams memory words in one of two patterns:
//   STREAM  (mode 1): P0 + i, i = 0..W-1
//   IMG2COL (mode 2): P0 + (oy+ky)*W + ox + kx over all KxK windows
// The words are delivered on a ready/valid output stream through a small FIFO.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   start, mode,      : command strobe (accepted only in S_IDLE), command mode,
//   param_base        : and the address of the parameter block
//   mem_rd_en,        : memory read request and its address
//   mem_addr
//   mem_rd_data       : read data, returned one cycle after mem_rd_en
//   m_valid, m_ready, : output stream handshake, data word,
//   m_data, m_last    : and final-word flag
//   state             : one-hot state {FIN, IMG2COL, STREAM, PARAM, IDLE}
//   busy, done, err   : not idle / one-cycle completion pulse / command rejected
module accel_seq #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 20,
  parameter int MODE_WIDTH = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [MODE_WIDTH-1:0] mode,
  input  logic [ADDR_WIDTH-1:0] param_base,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [4:0]            state,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // Address arithmetic width: wide enough for the unwrapped (oy+ky)*W + ox + kx
  // product and for the address itself; results are truncated afterwards.
  localparam int CW = (ADDR_WIDTH > 2*DATA_WIDTH+2) ? ADDR_WIDTH : 2*DATA_WIDTH+2;

  localparam logic [4:0] S_IDLE    = 5'b00001;
  localparam logic [4:0] S_PARAM   = 5'b00010;
  localparam logic [4:0] S_STREAM  = 5'b00100;
  localparam logic [4:0] S_IMG2COL = 5'b01000;
  localparam logic [4:0] S_FIN     = 5'b10000;

  localparam logic [MODE_WIDTH-1:0] MODE_STREAM = MODE_WIDTH'(1);
  localparam logic [MODE_WIDTH-1:0] MODE_IMG    = MODE_WIDTH'(2);

  function automatic logic [ADDR_WIDTH-1:0] to_addr(input logic [DATA_WIDTH-1:0] v);
    logic [CW-1:0] ext;
    ext = CW'(v);
    return ext[ADDR_WIDTH-1:0];
  endfunction

  // Wraps modulo 2^ADDR_WIDTH: truncating the full-width sum equals the
  // modular sum of its terms.
  function automatic logic [ADDR_WIDTH-1:0] img_addr(
    input logic [DATA_WIDTH-1:0] p0, w, oy, ky, ox, kx);
    logic [CW-1:0] row, col, off;
    row = CW'(oy) + CW'(ky);
    col = CW'(ox) + CW'(kx);
    off = row * CW'(w) + col + CW'(p0);
    return off[ADDR_WIDTH-1:0];
  endfunction

  // Control state (reset)
  logic [4:0]       state_q, state_d;
  logic [2:0]       pcnt_q, pcnt_d;
  logic [DATA_WIDTH-1:0] kx_q, kx_d, ky_q, ky_d, ox_q, ox_d, oy_q, oy_d;
  logic             issue_done_q, issue_done_d;
  logic             pend_q, pend_d, pend_last_q, pend_last_d;
  logic             err_q, err_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Command / parameter registers (no reset needed)
  logic [MODE_WIDTH-1:0] mode_q, mode_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [DATA_WIDTH-1:0] p0_q, p0_d, w_q, w_d, h_q, h_d;
  logic [DATA_WIDTH-1:0] kmax_q, kmax_d, oxmax_q, oxmax_d, oymax_q, oymax_d;

  // FIFO storage: {last, data}
  logic [DATA_WIDTH:0] fifo_mem [FIFO_DEPTH];

  logic in_data, is_img, fifo_push, fifo_pop, room, issue, last_issue, par_issue;
  logic [CNT_W:0] level;
  logic [DATA_WIDTH-1:0] k_in;
  logic k_bad;

  assign m_valid = (cnt_q != '0);
  assign m_data  = m_valid ? fifo_mem[rd_ptr_q][DATA_WIDTH-1:0] : '0;
  assign m_last  = m_valid ? fifo_mem[rd_ptr_q][DATA_WIDTH] : 1'b0;

  // ---- issue / flow control ----
  always_comb begin
    in_data   = state_q[2] | state_q[3];
    is_img    = state_q[3];
    fifo_push = pend_q;
    fifo_pop  = m_valid & m_ready;
    // Occupancy after this cycle's pop plus the word still in flight; counting
    // the pop is what allows one word per cycle at FIFO_DEPTH = 2.
    level     = {1'b0, cnt_q} + (CNT_W+1)'(pend_q) - (CNT_W+1)'(fifo_pop);
    room      = level < (CNT_W+1)'(FIFO_DEPTH);
    last_issue = is_img ? ((kx_q == kmax_q) && (ky_q == kmax_q) &&
                           (ox_q == oxmax_q) && (oy_q == oymax_q))
                        : (kx_q == kmax_q);
    issue     = in_data & ~issue_done_q & room;
    par_issue = state_q[1] & (pcnt_q != 3'd4);
    k_in      = mem_rd_data;
    k_bad     = (k_in == '0) | (k_in > w_q) | (k_in > h_q);
  end

  // ---- FSM: state register ----
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // ---- FSM: next state ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_PARAM;
      S_PARAM: begin
        if (pcnt_q == 3'd4) begin
          if (mode_q == MODE_STREAM)   state_d = (w_q == '0) ? S_FIN : S_STREAM;
          else if (mode_q == MODE_IMG) state_d = k_bad ? S_FIN : S_IMG2COL;
          else                         state_d = S_FIN;
        end
      end
      S_STREAM, S_IMG2COL: if (fifo_pop && m_last) state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  always_comb begin
    mem_rd_en = par_issue | issue;
    mem_addr  = '0;
    if (par_issue)  mem_addr = base_q + ADDR_WIDTH'(pcnt_q);
    else if (issue) mem_addr = is_img ? img_addr(p0_q, w_q, oy_q, ky_q, ox_q, kx_q)
                                      : to_addr(p0_q) + to_addr(kx_q);
    state = state_q;
    busy  = ~state_q[0];
    done  = state_q[4];
    err   = state_q[4] & err_q;
  end

  // ---- datapath next values ----
  always_comb begin
    pcnt_d = pcnt_q;  kx_d = kx_q;  ky_d = ky_q;  ox_d = ox_q;  oy_d = oy_q;
    issue_done_d = issue_done_q;
    err_d   = err_q;
    mode_d  = mode_q;  base_d = base_q;
    p0_d    = p0_q;    w_d = w_q;  h_d = h_q;
    kmax_d  = kmax_q;  oxmax_d = oxmax_q;  oymax_d = oymax_q;
    pend_d      = issue;
    pend_last_d = issue & last_issue;
    wr_ptr_d = wr_ptr_q + PTR_W'(fifo_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(fifo_pop);
    cnt_d    = cnt_q + CNT_W'(fifo_push) - CNT_W'(fifo_pop);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d = mode;
          base_d = param_base;
          pcnt_d = 3'd0;
          err_d  = 1'b0;
        end
      end
      S_PARAM: begin
        if (pcnt_q != 3'd4) pcnt_d = pcnt_q + 3'd1;
        // Data for read n arrives while pcnt_q = n+1.
        case (pcnt_q)
          3'd1: p0_d = mem_rd_data;
          3'd2: w_d  = mem_rd_data;
          3'd3: h_d  = mem_rd_data;
          3'd4: begin
            kx_d = '0;  ky_d = '0;  ox_d = '0;  oy_d = '0;
            issue_done_d = 1'b0;
            oxmax_d = '0;
            oymax_d = '0;
            if (mode_q == MODE_IMG) begin
              kmax_d  = k_in - 1'b1;
              oxmax_d = w_q - k_in;
              oymax_d = h_q - k_in;
              err_d   = k_bad;
            end else if (mode_q == MODE_STREAM) begin
              kmax_d = w_q - 1'b1;
              err_d  = 1'b0;
            end else begin
              kmax_d = '0;
              err_d  = 1'b1;
            end
          end
          default: ;
        endcase
      end
      S_STREAM, S_IMG2COL: begin
        if (issue) begin
          if (last_issue) begin
            issue_done_d = 1'b1;
          end else if (!is_img) begin
            kx_d = kx_q + 1'b1;
          end else if (kx_q != kmax_q) begin
            kx_d = kx_q + 1'b1;
          end else begin
            kx_d = '0;
            if (ky_q != kmax_q) begin
              ky_d = ky_q + 1'b1;
            end else begin
              ky_d = '0;
              if (ox_q != oxmax_q) begin
                ox_d = ox_q + 1'b1;
              end else begin
                ox_d = '0;
                oy_d = oy_q + 1'b1;
              end
            end
          end
        end
      end
      default: ;
    endcase
  end

  // ---- control registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q <= '0;  kx_q <= '0;  ky_q <= '0;  ox_q <= '0;  oy_q <= '0;
      issue_done_q <= 1'b0;
      pend_q       <= 1'b0;
      pend_last_q  <= 1'b0;
      err_q        <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
    end else begin
      pcnt_q <= pcnt_d;  kx_q <= kx_d;  ky_q <= ky_d;  ox_q <= ox_d;  oy_q <= oy_d;
      issue_done_q <= issue_done_d;
      pend_q       <= pend_d;
      pend_last_q  <= pend_last_d;
      err_q        <= err_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
    end
  end

  // ---- command / parameter registers ----
  always_ff @(posedge clk) begin
    mode_q  <= mode_d;   base_q  <= base_d;
    p0_q    <= p0_d;     w_q     <= w_d;     h_q <= h_d;
    kmax_q  <= kmax_d;   oxmax_q <= oxmax_d; oymax_q <= oymax_d;
  end

  // ---- FIFO storage ----
  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[wr_ptr_q] <= {pend_last_q, mem_rd_data};
  end

endmodule

// File: tb/tb_accel_seq.sv
`timescale 1ns/1ps
module tb_accel_seq;
  localparam int DW = 20;
  localparam int AW = 20;
  localparam int MW = 4;
  localparam int FD = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [MW-1:0] mode = '0;
  logic [AW-1:0] param_base = '0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rd_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic [4:0]    state;
  logic          busy, done, err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_mode = 0;
  int rdy_phase = 0;

  logic [DW-1:0] pmem [int];
  logic [AW-1:0] addr_q [$];
  logic [DW:0]   word_q [$];

  int rd_total = 0, cmd_start_rd = 0, prev_rd_cyc = -10;
  int iss_cnt = 0, xfer_cnt = 0, occ_bias = 0, last_xfer_cyc = -1;
  bit prev_stall = 1'b0;
  logic [DW-1:0] prev_d = '0;
  logic prev_l = 1'b0;

  accel_seq #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MODE_WIDTH(MW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .param_base(param_base),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .state(state), .busy(busy), .done(done), .err(err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Memory contents: parameter block overrides, otherwise a hash of the address.
  function automatic logic [DW-1:0] memval(input logic [AW-1:0] a);
    logic [31:0] h;
    if (pmem.exists(int'(a))) return pmem[int'(a)];
    h = {12'd0, a} * 32'd40503 + 32'h13579;
    return h[DW-1:0] ^ h[31:12];
  endfunction

  // Memory with one-cycle read latency.
  always @(posedge clk) mem_rd_data <= mem_rd_en ? memval(mem_addr) : 20'hBADBA;

  // m_ready patterns: 0 always, 1 the 1,0,0,1 toggle, 2 random, 3 held low.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: m_ready = 1'b1;
        1: m_ready = ((rdy_phase % 4) == 0) || ((rdy_phase % 4) == 3);
        2: m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b0;
      endcase
      rdy_phase++;
    end
  end

  // Monitor: read addresses, output words, stall stability, buffer occupancy.
  always @(negedge clk) begin : mon
    int idx;
    logic [AW-1:0] ea;
    logic [DW:0] wv;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk(m_valid && m_data == prev_d && m_last == prev_l, "stall_hold", m_data, prev_d);
      if (busy)
        chk((iss_cnt - xfer_cnt - occ_bias) <= FD, "occupancy", iss_cnt - xfer_cnt - occ_bias, FD);
      if (mem_rd_en) begin
        idx = rd_total - cmd_start_rd;
        chk(addr_q.size() != 0, "unexpected_read", mem_addr, 0);
        if (addr_q.size() != 0) begin
          ea = addr_q.pop_front();
          chk(mem_addr == ea, "rd_addr", mem_addr, ea);
        end
        if (idx >= 1 && idx <= 3) chk(cyc == prev_rd_cyc + 1, "param_gap", cyc - prev_rd_cyc, 1);
        if (idx >= 5 && rdy_mode == 0) chk(cyc == prev_rd_cyc + 1, "data_gap", cyc - prev_rd_cyc, 1);
        if (idx >= 4) iss_cnt++;
        prev_rd_cyc = cyc;
        rd_total++;
      end
      if (m_valid && m_ready) begin
        chk(word_q.size() != 0, "unexpected_word", m_data, 0);
        if (word_q.size() != 0) begin
          wv = word_q.pop_front();
          chk(m_data == wv[DW-1:0], "m_data", m_data, wv[DW-1:0]);
          chk(m_last == wv[DW], "m_last", m_last, wv[DW]);
          if (wv[DW]) last_xfer_cyc = cyc;
        end
        xfer_cnt++;
      end
      prev_stall = m_valid && !m_ready;
      prev_d = m_data;
      prev_l = m_last;
    end
  end

  // Reference model: expected read addresses and output words for one command.
  task automatic build_expected(input int md, input logic [AW-1:0] pb, input logic [DW-1:0] p0,
                                input int w, input int h, input int k,
                                output bit e_err, output int n);
    logic [AW-1:0] dq [$];
    logic [AW-1:0] a;
    bit legal_img;
    pmem.delete();
    for (int i = 0; i < 4; i++) begin
      a = pb + AW'(i);
      addr_q.push_back(a);
      case (i)
        0: pmem[int'(a)] = p0;
        1: pmem[int'(a)] = DW'(w);
        2: pmem[int'(a)] = DW'(h);
        default: pmem[int'(a)] = DW'(k);
      endcase
    end
    legal_img = (k != 0) && (k <= w) && (k <= h);
    if (md == 1) begin
      for (int i = 0; i < w; i++) dq.push_back(AW'(p0) + AW'(i));
    end else if (md == 2 && legal_img) begin
      for (int oy = 0; oy <= h - k; oy++)
        for (int ox = 0; ox <= w - k; ox++)
          for (int ky = 0; ky < k; ky++)
            for (int kx = 0; kx < k; kx++)
              dq.push_back(AW'(p0) + AW'((oy + ky) * w + ox + kx));
    end
    for (int i = 0; i < dq.size(); i++) begin
      addr_q.push_back(dq[i]);
      word_q.push_back({(i == dq.size() - 1), memval(dq[i])});
    end
    e_err = !(md == 1 || md == 2) || (md == 2 && !legal_img);
    n = dq.size();
  endtask

  task automatic issue_start(input int md, input logic [AW-1:0] pb);
    @(posedge clk);
    #1;
    cmd_start_rd = rd_total;
    mode = MW'(md);
    param_base = pb;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    mode = MW'($urandom);
    param_base = AW'($urandom);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    addr_q.delete();
    word_q.delete();
    occ_bias = iss_cnt - xfer_cnt;
  endtask

  task automatic run_cmd(input int md, input logic [AW-1:0] pb, input logic [DW-1:0] p0,
                         input int w, input int h, input int k, input bit glitch);
    bit e_err, seen;
    int n, budget;
    build_expected(md, pb, p0, w, h, k, e_err, n);
    budget = (n + 10) * 8 + 40;
    issue_start(md, pb);
    seen = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (glitch) start = (c == 8);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    start = 1'b0;
    chk(seen, "done_timeout", seen, 1);
    if (seen) begin
      chk(err == e_err, "err", err, e_err);
      chk(state == 5'b10000, "fin_state", state, 5'b10000);
      chk(word_q.size() == 0, "words_missing", word_q.size(), 0);
      chk(addr_q.size() == 0, "reads_missing", addr_q.size(), 0);
      if (n > 0) chk(cyc == last_xfer_cyc + 1, "fin_after_last", cyc - last_xfer_cyc, 1);
      @(negedge clk);
      chk(!done && state == 5'b00001 && !busy, "idle_after_fin", {done, busy, state}, 1);
    end else begin
      apply_reset();
    end
  endtask

  // Start a command, let it run, then reset it mid-flight.
  task automatic abort_cmd(input int md, input logic [AW-1:0] pb, input logic [DW-1:0] p0,
                           input int w, input int h, input int k, input int rmode);
    bit e_err;
    int n, vcnt;
    rdy_mode = rmode;
    build_expected(md, pb, p0, w, h, k, e_err, n);
    issue_start(md, pb);
    vcnt = 0;
    for (int c = 0; c < 60 && vcnt < 6; c++) begin
      @(negedge clk);
      if (m_valid) vcnt++;
    end
    chk(m_valid, "abort_pre_valid", m_valid, 1);
    chk(busy, "abort_pre_busy", busy, 1);
    apply_reset();
    @(negedge clk);
    chk(state == 5'b00001, "abort_state", state, 5'b00001);
    chk(!m_valid, "abort_m_valid", m_valid, 0);
    chk(!mem_rd_en, "abort_rd_en", mem_rd_en, 0);
    chk(!busy && !done && !err, "abort_flags", {busy, done, err}, 0);
    rdy_mode = 0;
  endtask

  initial begin
    int md, w, h, k;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(state == 5'b00001, "rst_state", state, 5'b00001);
    chk(!busy, "rst_busy", busy, 0);
    chk(!done, "rst_done", done, 0);
    chk(!err, "rst_err", err, 0);
    chk(!mem_rd_en, "rst_rd_en", mem_rd_en, 0);
    chk(mem_addr == '0, "rst_addr", mem_addr, 0);
    chk(!m_valid, "rst_m_valid", m_valid, 0);
    chk(!m_last, "rst_m_last", m_last, 0);
    chk(m_data == '0, "rst_m_data", m_data, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    rdy_mode = 0;
    run_cmd(1, 20'h00200, 20'h00100, 5, 0, 0, 1'b0);      // basic stream
    run_cmd(2, 20'h00800, 20'h00000, 4, 3, 2, 1'b0);      // img2col 24 words
    rdy_mode = 1;
    run_cmd(1, 20'h00300, 20'h01000, 8, 0, 0, 1'b1);      // stalls + ignored start
    rdy_mode = 0;
    run_cmd(3, 20'h00400, 20'h00010, 4, 4, 2, 1'b0);      // illegal mode
    run_cmd(2, 20'h00500, 20'h00000, 4, 6, 5, 1'b0);      // K > W
    run_cmd(2, 20'h00510, 20'h00000, 4, 4, 0, 1'b0);      // K = 0
    run_cmd(2, 20'h00520, 20'h00000, 4, 2, 3, 1'b0);      // K > H
    run_cmd(1, 20'h00530, 20'h00040, 0, 0, 0, 1'b0);      // empty stream
    run_cmd(1, 20'hFFFFE, 20'hFFFFE, 4, 0, 0, 1'b0);      // address wrap
    run_cmd(2, 20'h00540, 20'h00020, 3, 3, 3, 1'b0);      // single window

    abort_cmd(2, 20'h00900, 20'h00040, 4, 3, 2, 3);       // reset with FIFO full
    run_cmd(1, 20'h00700, 20'h02000, 3, 0, 0, 1'b0);
    abort_cmd(1, 20'h00910, 20'h03000, 30, 0, 0, 0);      // reset with reads in flight
    run_cmd(2, 20'h00710, 20'h00050, 3, 3, 2, 1'b0);

    for (int t = 0; t < 10; t++) begin
      md = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(1, 2));
      w = $urandom_range(0, 6);
      h = $urandom_range(1, 5);
      k = $urandom_range(0, 3);
      rdy_mode = $urandom_range(0, 2);
      run_cmd(md, AW'($urandom), DW'($urandom), w, h, k, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
